// File: rtl/gray_seq_gen.sv
// gray_seq_gen: Gray-code sequence generator with valid/ready output; optional up/down via GRAY_DIR_EN
module gray_seq_gen #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] start_val,
  input  logic         stop,
`ifdef GRAY_DIR_EN
  input  logic         dir,
`endif
  input  logic         out_ready,
  output logic [N-1:0] gray_out,
  output logic         out_valid,
  output logic         wrap,
  output logic         busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LAST = 2'd2;
  logic [1:0]   state;
  logic [N-1:0] bin;
  logic [N-1:0] bin_nxt;
  logic         down;
  logic         xfer;
  logic         term;
`ifdef GRAY_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif
  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  // next count and terminal-value detection, both following the direction sampled at the transfer
  always_comb begin
    xfer    = out_valid && out_ready;
    bin_nxt = down ? bin - 1'b1 : bin + 1'b1;
    term    = down ? (bin == '0) : (bin == '1);
  end
  // sequence FSM; gray_out is registered alongside bin so outputs never see inputs combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= xfer && term;
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          bin      <= start_val;
          gray_out <= start_val ^ (start_val >> 1);
        end
        RUN: if (xfer && stop) state <= IDLE;
        else if (xfer) begin
          bin      <= bin_nxt;
          gray_out <= bin_nxt ^ (bin_nxt >> 1);
        end else if (stop) state <= LAST;
        LAST: if (xfer) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_seq_gen.sv
// tb_gray_seq_gen: scoreboard bench for gray_seq_gen at N=4, decoding gray_out through a g2b model
module tb_gray_seq_gen;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] start_val = '0;
  logic         stop = 1'b0;
  logic         dir = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] gray_out;
  logic         out_valid;
  logic         wrap;
  logic         busy;
  int           vec = 0;
  int           err = 0;
  logic [N-1:0] q[$];
  logic [N-1:0] e;
  logic [N-1:0] prev;
  logic [N-1:0] prev_gray;
  logic         have_prev;
  logic         prev_down;

  gray_seq_gen #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .start_val(start_val),
    .stop(stop),
`ifdef GRAY_DIR_EN
    .dir(dir),
`endif
    .out_ready(out_ready),
    .gray_out(gray_out),
    .out_valid(out_valid),
    .wrap(wrap),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [N-1:0] gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (gray_out !== 4'd0) begin err++; $display("FAIL reset_gray got %0d want 0", gray_out); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vec++; if (wrap !== 1'b0) begin err++; $display("FAIL reset_wrap got %b want 0", wrap); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_count;
    @(negedge clk);
    start = 1'b1; start_val = 4'd0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) q.push_back(4'(i));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      vec++; if (out_valid !== 1'b1 || busy !== 1'b1) begin err++; $display("FAIL count_valid beat %0d got valid=%b busy=%b want 1/1", i, out_valid, busy); end
      e = q.pop_front();
      vec++; if (gray_out !== gray(e) || g2b(gray_out) !== e) begin err++; $display("FAIL count_gray beat %0d got %0d want %0d", i, gray_out, gray(e)); end
      stop = (i == 5);
    end
    @(negedge clk);
    stop = 1'b0;
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL count_stop got valid=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_wrap;
    start = 1'b1; start_val = 4'd14; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(4'(14 + i));
    have_prev = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      e = q.pop_front();
      vec++; if (gray_out !== gray(e) || g2b(gray_out) !== e || out_valid !== 1'b1) begin err++; $display("FAIL wrap_gray beat %0d got %0d valid=%b want %0d", i, gray_out, out_valid, gray(e)); end
      vec++; if (wrap !== (have_prev && prev == 4'd15)) begin err++; $display("FAIL wrap_pulse beat %0d got %b want %b", i, wrap, have_prev && prev == 4'd15); end
      if (have_prev) begin
        vec++; if ($countones(gray_out ^ prev_gray) != 1) begin err++; $display("FAIL wrap_onebit beat %0d got %0d->%0d want one bit change", i, prev_gray, gray_out); end
      end
      prev = e; prev_gray = gray_out; have_prev = 1'b1;
      stop = (i == 3);
    end
    @(negedge clk);
    stop = 1'b0;
    vec++; if (wrap !== 1'b0 || out_valid !== 1'b0) begin err++; $display("FAIL wrap_end got wrap=%b valid=%b want 0/0", wrap, out_valid); end
  endtask

  task automatic test_backpressure;
    start = 1'b1; start_val = 4'd2; out_ready = 1'b0;
    q.push_back(4'd2); q.push_back(4'd3);
    e = q.pop_front();
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      vec++; if (gray_out !== gray(e) || out_valid !== 1'b1) begin err++; $display("FAIL bp_hold cycle %0d got %0d valid=%b want %0d valid=1", i, gray_out, out_valid, gray(e)); end
      out_ready = (i == 3);
    end
    @(negedge clk);
    e = q.pop_front();
    vec++; if (gray_out !== gray(e) || g2b(gray_out) !== e || out_valid !== 1'b1) begin err++; $display("FAIL bp_advance got %0d want %0d", gray_out, gray(e)); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL bp_stop got valid=%b want 0", out_valid); end
  endtask

  task automatic test_stop_last;
    start = 1'b1; start_val = 4'd4; out_ready = 1'b0;
    q.push_back(4'd4);
    @(negedge clk);
    start = 1'b0;
    e = q.pop_front();
    vec++; if (gray_out !== gray(e) || out_valid !== 1'b1) begin err++; $display("FAIL last_first got %0d want %0d", gray_out, gray(e)); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b1; start_val = 4'd9;
    vec++; if (gray_out !== gray(e) || out_valid !== 1'b1 || busy !== 1'b1) begin err++; $display("FAIL last_hold got %0d valid=%b busy=%b want %0d 1 1", gray_out, out_valid, busy, gray(e)); end
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    vec++; if (gray_out !== gray(e) || out_valid !== 1'b1) begin err++; $display("FAIL last_start_ignored got %0d valid=%b want %0d 1", gray_out, out_valid, gray(e)); end
    @(negedge clk);
    vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || gray_out !== gray(e)) begin err++; $display("FAIL last_idle got %0d valid=%b busy=%b want %0d 0 0", gray_out, out_valid, busy, gray(e)); end
    start = 1'b1; start_val = 4'd5;
    q.push_back(4'd5);
    @(negedge clk);
    start = 1'b0;
    e = q.pop_front();
    vec++; if (gray_out !== 4'd7 || g2b(gray_out) !== e || out_valid !== 1'b1) begin err++; $display("FAIL last_restart got %0d valid=%b want 7", gray_out, out_valid); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset_midrun;
    start = 1'b1; start_val = 4'd3; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vec++; if (out_valid !== 1'b1 || gray_out !== gray(4'd3)) begin err++; $display("FAIL rstrun_pre got %0d valid=%b want %0d 1", gray_out, out_valid, gray(4'd3)); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++; if (out_valid !== 1'b0 || gray_out !== 4'd0 || busy !== 1'b0 || wrap !== 1'b0) begin err++; $display("FAIL rstrun got %0d valid=%b busy=%b wrap=%b want 0 0 0 0", gray_out, out_valid, busy, wrap); end
  endtask

`ifdef GRAY_DIR_EN
  task automatic test_dir;
    logic [N-1:0] vals [5];
    vals = '{4'd1, 4'd0, 4'd15, 4'd14, 4'd15};
    start = 1'b1; start_val = 4'd1; dir = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) q.push_back(vals[i]);
    have_prev = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      e = q.pop_front();
      vec++; if (gray_out !== gray(e) || g2b(gray_out) !== e || out_valid !== 1'b1) begin err++; $display("FAIL dir_gray beat %0d got %0d want %0d", i, gray_out, gray(e)); end
      vec++; if (wrap !== (have_prev && (prev_down ? prev == 4'd0 : prev == 4'd15))) begin err++; $display("FAIL dir_wrap beat %0d got %b", i, wrap); end
      if (i == 3) dir = 1'b0;
      prev = e; prev_down = dir; have_prev = 1'b1;
      stop = (i == 4);
    end
    @(negedge clk);
    stop = 1'b0;
    vec++; if (wrap !== 1'b1 || out_valid !== 1'b0) begin err++; $display("FAIL dir_stopwrap got wrap=%b valid=%b want 1/0", wrap, out_valid); end
  endtask
`endif

  initial begin
    test_reset;
    test_count;
    test_wrap;
    test_backpressure;
    test_stop_last;
    test_reset_midrun;
`ifdef GRAY_DIR_EN
    test_dir;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
